// File: rtl/ikascc_slotbus_pkg.sv
// Shared FSM state type and chip-select page decode for the slot bus initiator.
package ikascc_slotbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3
    } state_e;

    localparam logic [1:0] PAGE_CS_LO = 2'b01;
    localparam logic [1:0] PAGE_CS_HI = 2'b10;

    // The slot only answers in the two middle 16K pages of the address space.
    function automatic logic slot_selected(input logic [15:0] addr);
        return (addr[15:14] == PAGE_CS_LO) || (addr[15:14] == PAGE_CS_HI);
    endfunction

endpackage

// File: rtl/ikascc_slotbus_init_if.sv
// Request/response handshake plus slot bus pins; master is the initiator's view.
interface ikascc_slotbus_init_if;

    logic        i_REQ;
    logic        i_REQ_WR;
    logic [15:0] i_REQ_ADDR;
    logic [7:0]  i_REQ_WDATA;
    logic        o_REQ_ACK;
    logic        o_RSP_VALID;
    logic [7:0]  o_RSP_RDATA;
    logic        o_RSP_TMO;
    logic        o_CS_n;
    logic        o_RD_n;
    logic        o_WR_n;
    logic [15:0] o_AB;
    logic [7:0]  o_DB;
    logic        o_DB_OE;
    logic [7:0]  i_DB;
    logic        i_WAIT_n;

    modport master (
        input  i_REQ, i_REQ_WR, i_REQ_ADDR, i_REQ_WDATA, i_DB, i_WAIT_n,
        output o_REQ_ACK, o_RSP_VALID, o_RSP_RDATA, o_RSP_TMO,
        output o_CS_n, o_RD_n, o_WR_n, o_AB, o_DB, o_DB_OE
    );

    modport slave (
        output i_REQ, i_REQ_WR, i_REQ_WDATA, i_REQ_ADDR, i_DB, i_WAIT_n,
        input  o_REQ_ACK, o_RSP_VALID, o_RSP_RDATA, o_RSP_TMO,
        input  o_CS_n, o_RD_n, o_WR_n, o_AB, o_DB, o_DB_OE
    );

endinterface

// File: rtl/ikascc_slotbus_init.sv
// Slot bus cycle initiator: IDLE/T1/T2/(TW)/T3 sequence advanced on phiM ticks.
// Define IKASCC_SLOTBUS_WAIT_EN to honour i_WAIT_n with a TW_MAX wait timeout.
module ikascc_slotbus_init
    import ikascc_slotbus_pkg::*;
#(
    parameter logic [7:0] TW_MAX       = 8'd255,
    parameter logic [7:0] RD_IDLE_DATA = 8'hFF
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_RST_n,
    input  logic                  i_MCLK_PCEN_n,
    ikascc_slotbus_init_if.master bus
);

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        ack_q, ack_d;
    logic        valid_q, valid_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        tick;
    logic        active;
    logic        strobe;

`ifdef IKASCC_SLOTBUS_WAIT_EN
    logic [7:0]  wcnt_q, wcnt_d;
    logic        tmoPend_q, tmoPend_d;
    logic        tmo_q, tmo_d;
`endif

    assign tick = ~i_MCLK_PCEN_n;

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            valid_q   <= 1'b0;
            rdata_q   <= 8'hFF;
`ifdef IKASCC_SLOTBUS_WAIT_EN
            wcnt_q    <= '0;
            tmoPend_q <= 1'b0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            ack_q     <= ack_d;
            valid_q   <= valid_d;
            rdata_q   <= rdata_d;
`ifdef IKASCC_SLOTBUS_WAIT_EN
            wcnt_q    <= wcnt_d;
            tmoPend_q <= tmoPend_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Pulses default low so they last exactly one EMUCLK after the tick that raised them.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        ack_d     = 1'b0;
        valid_d   = 1'b0;
        rdata_d   = rdata_q;
`ifdef IKASCC_SLOTBUS_WAIT_EN
        wcnt_d    = wcnt_q;
        tmoPend_d = tmoPend_q;
        tmo_d     = tmo_q;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_REQ) begin
                        addr_d  = bus.i_REQ_ADDR;
                        wr_d    = bus.i_REQ_WR;
                        wdata_d = bus.i_REQ_WDATA;
                        ack_d   = 1'b1;
                        state_d = ST_T1;
                    end
                end
                ST_T1: state_d = ST_T2;
                ST_T2: begin
                    state_d = ST_T3;
`ifdef IKASCC_SLOTBUS_WAIT_EN
                    wcnt_d    = '0;
                    tmoPend_d = 1'b0;
                    if (!bus.i_WAIT_n) state_d = ST_TW;
`endif
                end
`ifdef IKASCC_SLOTBUS_WAIT_EN
                // A released wait on the same tick the limit is hit still ends normally.
                ST_TW: begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (bus.i_WAIT_n) begin
                        state_d = ST_T3;
                    end else if (wcnt_d == TW_MAX) begin
                        state_d   = ST_T3;
                        tmoPend_d = 1'b1;
                    end
                end
`endif
                ST_T3: begin
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
`ifdef IKASCC_SLOTBUS_WAIT_EN
                    tmo_d = tmoPend_q;
                    if (!wr_q) rdata_d = tmoPend_q ? RD_IDLE_DATA : bus.i_DB;
`else
                    if (!wr_q) rdata_d = bus.i_DB;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign active = (state_q != ST_IDLE);
    assign strobe = (state_q == ST_T2) || (state_q == ST_TW) || (state_q == ST_T3);

    assign bus.o_REQ_ACK   = ack_q;
    assign bus.o_RSP_VALID = valid_q;
    assign bus.o_RSP_RDATA = rdata_q;
    assign bus.o_AB        = addr_q;
    assign bus.o_DB        = wdata_q;
    assign bus.o_DB_OE     = active & wr_q;
    assign bus.o_CS_n      = ~(active & slot_selected(addr_q));
    assign bus.o_RD_n      = ~(strobe & ~wr_q);
    assign bus.o_WR_n      = ~(strobe & wr_q);
`ifdef IKASCC_SLOTBUS_WAIT_EN
    assign bus.o_RSP_TMO   = tmo_q;
`else
    assign bus.o_RSP_TMO   = 1'b0;
`endif

endmodule

// File: tb/tb_ikascc_slotbus_init.sv
// Randomised self-checking bench for ikascc_slotbus_init against a transaction-level model.
// Wait/timeout expectations follow IKASCC_SLOTBUS_WAIT_EN, like the design.
module tb_ikascc_slotbus_init;

    localparam logic [7:0] TB_TW_MAX = 8'd12;

    logic       clk = 1'b0;
    logic       rstN;
    logic       pcenN;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] expRdata;

    ikascc_slotbus_init_if bus ();

    ikascc_slotbus_init #(
        .TW_MAX      (TB_TW_MAX),
        .RD_IDLE_DATA(8'hFF)
    ) dut (
        .i_EMUCLK     (clk),
        .i_RST_n      (rstN),
        .i_MCLK_PCEN_n(pcenN),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // One phiM tick, preceded by a random number of non-tick clocks that must change nothing.
    task automatic advanceTick();
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            pcenN = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("noTickAck", bus.o_REQ_ACK, 0);
            checkOutput("noTickValid", bus.o_RSP_VALID, 0);
        end
        @(negedge clk);
        pcenN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("strobeExcl", (!bus.o_RD_n && !bus.o_WR_n), 0);
    endtask

    // One complete request; waitLen = consecutive ticks i_WAIT_n is low starting at the T2 tick.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                                 input int waitLen, input int dbFix, input bit holdReq);
        int         twExp;
        int         lastTick;
        bit         tmoExp;
        logic       csExp;
        logic [7:0] dbVal;
`ifdef IKASCC_SLOTBUS_WAIT_EN
        twExp  = (waitLen > int'(TB_TW_MAX)) ? int'(TB_TW_MAX) : waitLen;
        tmoExp = (waitLen > int'(TB_TW_MAX));
`else
        twExp  = 0;
        tmoExp = 1'b0;
`endif
        lastTick = 3 + twExp;
        csExp    = (addr >= 16'h4000) && (addr < 16'hC000);

        bus.i_REQ       = 1'b1;
        bus.i_REQ_WR    = wr;
        bus.i_REQ_ADDR  = addr;
        bus.i_REQ_WDATA = wdata;
        bus.i_WAIT_n    = 1'b1;
        bus.i_DB        = 8'($urandom);
        advanceTick();
        checkOutput("ack", bus.o_REQ_ACK, 1);
        checkOutput("t1Valid", bus.o_RSP_VALID, 0);
        checkOutput("t1Addr", bus.o_AB, addr);
        checkOutput("t1Cs", bus.o_CS_n, !csExp);
        checkOutput("t1Oe", bus.o_DB_OE, wr);
        checkOutput("t1Strobes", {bus.o_RD_n, bus.o_WR_n}, 2'b11);
        if (wr) checkOutput("t1Db", bus.o_DB, wdata);

        for (int k = 1; k <= lastTick; k++) begin
            if (!holdReq) bus.i_REQ = 1'b0;
            bus.i_WAIT_n = (k >= 2 && k < 2 + waitLen) ? 1'b0 : 1'b1;
            dbVal = (dbFix >= 0) ? 8'(dbFix) : 8'($urandom);
            bus.i_DB = dbVal;
            advanceTick();
            checkOutput("busyAck", bus.o_REQ_ACK, 0);
            if (k == lastTick) begin
                if (!wr) expRdata = tmoExp ? 8'hFF : dbVal;
                checkOutput("rspValid", bus.o_RSP_VALID, 1);
                checkOutput("rspRdata", bus.o_RSP_RDATA, expRdata);
                checkOutput("rspTmo", bus.o_RSP_TMO, tmoExp);
                checkOutput("endStrobes", {bus.o_RD_n, bus.o_WR_n}, 2'b11);
                checkOutput("endCs", bus.o_CS_n, 1);
                checkOutput("endOe", bus.o_DB_OE, 0);
            end else begin
                checkOutput("midValid", bus.o_RSP_VALID, 0);
                checkOutput("addrHold", bus.o_AB, addr);
                checkOutput("midCs", bus.o_CS_n, !csExp);
                checkOutput("midOe", bus.o_DB_OE, wr);
                checkOutput("rdStrobe", bus.o_RD_n, wr);
                checkOutput("wrStrobe", bus.o_WR_n, !wr);
            end
        end
        if (!holdReq) bus.i_REQ = 1'b0;
        bus.i_WAIT_n = 1'b1;
    endtask

    // Write aborted by reset while in T2; nothing may be reported for it.
    task automatic abortWrite();
        bus.i_REQ       = 1'b1;
        bus.i_REQ_WR    = 1'b1;
        bus.i_REQ_ADDR  = 16'h8123;
        bus.i_REQ_WDATA = 8'hC3;
        bus.i_WAIT_n    = 1'b1;
        advanceTick();
        checkOutput("abortAck", bus.o_REQ_ACK, 1);
        bus.i_REQ = 1'b0;
        advanceTick();
        checkOutput("abortWrLow", bus.o_WR_n, 0);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abortWrN", bus.o_WR_n, 1);
        checkOutput("abortRdN", bus.o_RD_n, 1);
        checkOutput("abortCsN", bus.o_CS_n, 1);
        checkOutput("abortOe", bus.o_DB_OE, 0);
        checkOutput("abortAb", bus.o_AB, 0);
        checkOutput("abortDb", bus.o_DB, 0);
        checkOutput("abortValid", bus.o_RSP_VALID, 0);
        checkOutput("abortRdata", bus.o_RSP_RDATA, 8'hFF);
        checkOutput("abortTmo", bus.o_RSP_TMO, 0);
        expRdata = 8'hFF;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            advanceTick();
            checkOutput("postAbortValid", bus.o_RSP_VALID, 0);
            checkOutput("postAbortAck", bus.o_REQ_ACK, 0);
        end
    endtask

    initial begin
        rstN            = 1'b0;
        pcenN           = 1'b1;
        bus.i_REQ       = 1'b0;
        bus.i_REQ_WR    = 1'b0;
        bus.i_REQ_ADDR  = '0;
        bus.i_REQ_WDATA = '0;
        bus.i_DB        = '0;
        bus.i_WAIT_n    = 1'b1;
        expRdata        = 8'hFF;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstCsN", bus.o_CS_n, 1);
        checkOutput("rstRdWr", {bus.o_RD_n, bus.o_WR_n}, 2'b11);
        checkOutput("rstOe", bus.o_DB_OE, 0);
        checkOutput("rstAb", bus.o_AB, 0);
        checkOutput("rstDb", bus.o_DB, 0);
        checkOutput("rstPulses", {bus.o_REQ_ACK, bus.o_RSP_VALID, bus.o_RSP_TMO}, 3'b000);
        checkOutput("rstRdata", bus.o_RSP_RDATA, 8'hFF);
        @(negedge clk);
        rstN = 1'b1;

        applyStimulus(1'b1, 16'h9000, 8'h3F, 0, -1, 1'b0);
        applyStimulus(1'b0, 16'h9800, 8'h00, 0, 8'h5A, 1'b0);
        applyStimulus(1'b0, 16'h0100, 8'h00, 0, -1, 1'b0);
        applyStimulus(1'b0, 16'h4321, 8'h00, 5, -1, 1'b0);
        applyStimulus(1'b0, 16'hBFFF, 8'h00, int'(TB_TW_MAX), -1, 1'b0);
        applyStimulus(1'b0, 16'h7000, 8'h00, int'(TB_TW_MAX) + 1, -1, 1'b0);
        applyStimulus(1'b0, 16'h5000, 8'h00, 1000, -1, 1'b0);
        applyStimulus(1'b1, 16'hC000, 8'h77, 1000, -1, 1'b0);

        applyStimulus(1'b0, 16'hA000, 8'h00, 0, -1, 1'b1);
        applyStimulus(1'b1, 16'h5555, 8'hE1, 0, -1, 1'b0);

        abortWrite();
        applyStimulus(1'b1, 16'h6000, 8'h12, 0, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 3);
            applyStimulus(1'($urandom), 16'($urandom), 8'($urandom), w, -1, 1'($urandom));
        end

        bus.i_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advanceTick();
            checkOutput("idleAck", bus.o_REQ_ACK, 0);
            checkOutput("idleValid", bus.o_RSP_VALID, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ikascc_slotbus_init.md
IKASCC_SLOTBUS_INIT -- requirements
Module: ikascc_slotbus_init

Interface
REQ-001 SHALL have parameter TW_MAX, default 8'd255, meaning the maximum number of wait ticks before a cycle times out.
REQ-002 SHALL have parameter RD_IDLE_DATA, default 8'hFF, meaning the read data returned on timeout.
REQ-003 SHALL have port i_EMUCLK  in  1  emulator master clock; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port i_RST_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port i_MCLK_PCEN_n  in  1  phiM positive-edge clock enable (negative logic); one asserted cycle = one "tick".
REQ-006 SHALL have port i_REQ  in  1  cycle request, held high by requester until acknowledged.
REQ-007 SHALL have port i_REQ_WR  in  1  1=write cycle, 0=read cycle.
REQ-008 SHALL have port i_REQ_ADDR  in  16  target address.
REQ-009 SHALL have port i_REQ_WDATA  in  8  write data.
REQ-010 SHALL have port o_REQ_ACK  out  1  one-EMUCLK pulse on request acceptance.
REQ-011 SHALL have port o_RSP_VALID  out  1  one-EMUCLK pulse at cycle end.
REQ-012 SHALL have port o_RSP_RDATA  out  8  read data, held until next o_RSP_VALID.
REQ-013 SHALL have port o_RSP_TMO  out  1  timeout flag, qualified by o_RSP_VALID.
REQ-014 SHALL have port o_CS_n  out  1  slot chip select.
REQ-015 SHALL have port o_RD_n  out  1  read strobe.
REQ-016 SHALL have port o_WR_n  out  1  write strobe.
REQ-017 SHALL have port o_AB  out  16  address bus.
REQ-018 SHALL have port o_DB  out  8  data bus output.
REQ-019 SHALL have port o_DB_OE  out  1  data bus output enable.
REQ-020 SHALL have port i_DB  in  8  data bus input.
REQ-021 SHALL have port i_WAIT_n  in  1  slot wait request, active low.

Function
REQ-022 SHALL change state only on EMUCLK edges where i_MCLK_PCEN_n=0, except for async reset; o_REQ_ACK and o_RSP_VALID are each high for exactly that one EMUCLK cycle.
REQ-023 SHALL implement FSM states IDLE, T1, T2, TW, T3.
REQ-024 SHALL, in IDLE on a tick with i_REQ=1, latch ADDR/WR/WDATA, pulse o_REQ_ACK and go to T1; i_REQ while not IDLE is ignored with no ACK.
REQ-025 SHALL, in T1, drive o_AB=latched address; o_CS_n=0 iff addr[15:14] is 2'b01 or 2'b10; o_DB_OE=1 with o_DB=WDATA for writes; advance to T2.
REQ-026 SHALL, in T2, drive o_RD_n=0 for reads or o_WR_n=0 for writes; advance to TW if wait is active, else to T3.
REQ-027 SHALL, in TW, keep the strobes asserted and increment an 8-bit wait counter per tick; exit to T3 when i_WAIT_n=1, or force timeout when counter reaches TW_MAX.
REQ-028 SHALL, on the T3 tick, capture i_DB into o_RSP_RDATA for reads (writes leave it unchanged), deassert o_RD_n/o_WR_n/o_CS_n, clear o_DB_OE, pulse o_RSP_VALID and return to IDLE.
REQ-029 SHALL, on timeout, set o_RSP_TMO=1 and o_RSP_RDATA=RD_IDLE_DATA for reads; o_RSP_TMO=0 otherwise.
REQ-030 SHALL complete a no-wait cycle with o_RSP_VALID exactly 3 ticks after o_REQ_ACK; minimum request-to-request spacing is 4 ticks.
REQ-031 SHALL keep o_AB stable from T1 through T3 inclusive and never assert o_RD_n and o_WR_n together.

Reset
REQ-032 SHALL, on i_RST_n=0 (async, including mid-cycle), force IDLE; o_CS_n=o_RD_n=o_WR_n=1; o_DB_OE=0; o_AB=0; o_DB=0; o_REQ_ACK=o_RSP_VALID=o_RSP_TMO=0; o_RSP_RDATA=8'hFF; wait counter=0.
REQ-033 SHALL, for an aborted cycle, issue no o_RSP_VALID.

Configuration
REQ-034 SHALL, with macro IKASCC_SLOTBUS_WAIT_EN defined, sample i_WAIT_n in T2/TW as specified in REQ-027.
REQ-035 SHALL, without IKASCC_SLOTBUS_WAIT_EN, ignore i_WAIT_n, never enter TW, tie o_RSP_TMO to 0 and omit the wait counter.

Structure
REQ-036 SHALL place the FSM state enum and the CS decode page constants in a shared package ikascc_slotbus_pkg.
REQ-037 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-038 SHALL verify: write 0x9000<=0x3F, no wait -> CS_n=0; WR_n low for T2–T3; DB_OE=1; RSP_VALID 3 ticks after ACK; TMO=0.
REQ-039 SHALL verify: read 0x9800 with i_DB=0x5A -> RD_n low; RSP_RDATA=0x5A; no WR_n activity.
REQ-040 SHALL verify: read 0x0100 -> CS_n stays 1; RD_n strobes; response is returned normally.
REQ-041 SHALL verify, with IKASCC_SLOTBUS_WAIT_EN: i_WAIT_n low 5 ticks -> exactly 5 TW ticks; RSP at ACK+8 ticks; i_WAIT_n stuck low -> TMO=1, RDATA=0xFF after TW_MAX TW ticks.
REQ-042 SHALL verify: reset asserted in T2 of a write -> strobes high and DB_OE=0 immediately; no RSP_VALID; next request accepted normally.
REQ-043 SHALL verify: i_REQ held during a busy cycle -> no second ACK until IDLE; ACK arrives on the first IDLE tick.
